spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_master_shifter.sv | 43 ++++
 rtl/spi_master.sv | 159 +++++++++++++++
 tb/tb_spi_master.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command encodings, frame widths
// and the master state enum.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    TURN,
    RECV,
    GAP
  } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Transmit (10-bit, MSB first) and receive (8-bit, MSB first) shift
// registers for the SPI master, driven by strobes from the state machine.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic               i_sample,
  input  logic               i_clr,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_miso,
  output logic               o_mosi,
  output logic [DATA_W-1:0]  o_rx_next
);

  logic [FRAME_W-1:0] r_tx;
  logic [DATA_W-1:0]  r_rx;

  // Zeros are shifted in behind the frame so MOSI idles low afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_tx <= '0;
    end else if (i_load) begin
      r_tx <= i_frame;
    end else if (i_shift) begin
      r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_rx <= '0;
    end else if (i_sample) begin
      r_rx <= o_rx_next;
    end
  end

  assign o_mosi    = r_tx[FRAME_W-1];
  assign o_rx_next = {r_rx[DATA_W-2:0], i_miso};

endmodule

// File: rtl/spi_master.sv
// SPI master: 10-bit command frames with optional read-data turnaround.
// Define SPI_MASTER_ABORT_EN to add the abort input.
module spi_master
  import spi_pkg::*;
#(
  parameter int TURNAROUND = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_t              r_state;
  state_t              w_nxt;
  logic [3:0]          r_cnt;
  logic                r_ready;
  logic                r_ss_n;
  logic                r_is_rd;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_abort;
  logic                w_load;
  logic                w_shift;
  logic                w_sample;
  logic                w_clr;
  logic                w_done;
  logic [DATA_W-1:0]   w_rx_next;

`ifdef SPI_MASTER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_nxt    = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_sample = 1'b0;
    w_clr    = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid && r_ready) begin
          w_nxt  = SHIFT;
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == SHIFT_LAST) begin
          w_nxt = r_is_rd ? TURN : GAP;
        end
      end
      TURN: begin
        if (r_cnt == TURN_LAST) begin
          w_nxt = RECV;
        end
      end
      RECV: begin
        w_sample = 1'b1;
        if (r_cnt == RECV_LAST) begin
          w_nxt  = GAP;
          w_done = 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
    // Abort overrides every strobe so no partial byte is published.
    if (w_abort && (r_state inside {SHIFT, TURN, RECV})) begin
      w_nxt    = GAP;
      w_shift  = 1'b0;
      w_sample = 1'b0;
      w_done   = 1'b0;
      w_clr    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_nxt != r_state) || (r_state == IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_ss_n     <= 1'b1;
      r_is_rd    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ready    <= (w_nxt == IDLE);
      r_ss_n     <= !(w_nxt inside {SHIFT, TURN, RECV});
      r_rd_valid <= w_done;
      if (w_load) begin
        r_is_rd <= (cmd_t'(cmd_type) == CMD_RD_DATA);
      end
      if (w_done) begin
        r_rd_data <= w_rx_next;
      end
    end
  end

  spi_master_shifter u_shifter (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_sample  (w_sample),
    .i_clr     (w_clr),
    .i_frame   ({cmd_type, cmd_data}),
    .i_miso    (MISO),
    .o_mosi    (MOSI),
    .o_rx_next (w_rx_next)
  );

  assign cmd_ready = r_ready;
  assign SS_n      = r_ss_n;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed and random frames compared
// cycle by cycle against a frame-level reference model.
module tb_spi_master;

  localparam int T = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       MISO = 1'b0;
  logic       abort = 1'b0;
  logic       cmd_ready;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_rd = 8'h00;

  always #5 clk = ~clk;

  spi_master #(
    .TURNAROUND (T),
    .GAP_CYCLES (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_data  (cmd_data),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy)
`ifdef SPI_MASTER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: cycles 1..10 carry the frame MSB first; a read adds T quiet
  // cycles and 8 sampled cycles; then G gap cycles; ready the cycle after.
  task automatic frame(input logic [1:0] t, input logic [7:0] d,
                       input logic [7:0] mb, input bit hold,
                       input bit perturb);
    logic [9:0] f;
    bit         rd;
    int         act;
    int         len;
    f   = {t, d};
    rd  = (t == 2'b11);
    act = 10 + (rd ? T + 8 : 0);
    len = act + G;
    chk("ready_pre", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    for (int k = 1; k <= len; k++) begin
      step();
      if (k == 1 && !hold) cmd_valid = 1'b0;
      if (perturb && k == 4) begin
        cmd_valid = 1'b1;
        cmd_type  = t ^ 2'b11;
        cmd_data  = ~d;
      end
      if (rd && k > 10 + T && k <= act) MISO = mb[7-(k-11-T)];
      else MISO = 1'($urandom);
      if (rd && k == act + 1) exp_rd = mb;
      chk("ss_n", 32'(SS_n), 32'(k > act));
      chk("mosi", 32'(MOSI), (k <= 10) ? 32'(f[10-k]) : 0);
      chk("ready_busy", 32'(cmd_ready), 0);
      chk("busy", 32'(busy), 1);
      chk("rd_valid", 32'(rd_valid), 32'(rd && k == act + 1));
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
    end
    step();
    chk("ready_end", 32'(cmd_ready), 1);
    chk("busy_end", 32'(busy), 0);
    chk("ss_n_end", 32'(SS_n), 1);
    chk("mosi_end", 32'(MOSI), 0);
    chk("rd_valid_end", 32'(rd_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] t;
    logic [7:0] d;
    logic [7:0] mb;
    bit         h;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_ss_n", 32'(SS_n), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 1);

    frame(2'b00, 8'hA5, 8'h00, 1'b0, 1'b0);
    frame(2'b11, 8'h00, 8'h3C, 1'b0, 1'b0);

    frame(2'b01, 8'($urandom), 8'h00, 1'b1, 1'b0);
    frame(2'b01, 8'($urandom), 8'h00, 1'b0, 1'b0);

    frame(2'b01, 8'($urandom), 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      t  = 2'($urandom);
      d  = 8'($urandom);
      mb = 8'($urandom);
      h  = (i != 15) && ($urandom_range(0, 1) == 1);
      frame(t, d, mb, h, 1'b0);
    end
    cmd_valid = 1'b0;

    frame(2'b11, 8'($urandom), 8'hC3, 1'b0, 1'b0);

    cmd_valid = 1'b1;
    cmd_type  = 2'b11;
    cmd_data  = 8'($urandom);
    step();
    cmd_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("mid_rst_pre_ss_n", 32'(SS_n), 0);
    end
    rst = 1'b1;
    step();
    exp_rd = 8'h00;
    chk("mid_rst_ss_n", 32'(SS_n), 1);
    chk("mid_rst_mosi", 32'(MOSI), 0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'(exp_rd));
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_ready", 32'(cmd_ready), 1);
      chk("post_rst_rd_valid", 32'(rd_valid), 0);
      chk("post_rst_rd_data", 32'(rd_data), 0);
    end

`ifdef SPI_MASTER_ABORT_EN
    frame(2'b11, 8'h00, 8'h5A, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_type  = 2'b11;
    cmd_data  = 8'($urandom);
    step();
    cmd_valid = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      step();
      MISO = 1'($urandom);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int g = 1; g <= G; g++) begin
      if (g > 1) step();
      chk("abort_ss_n", 32'(SS_n), 1);
      chk("abort_mosi", 32'(MOSI), 0);
      chk("abort_rd_valid", 32'(rd_valid), 0);
      chk("abort_ready", 32'(cmd_ready), 0);
    end
    step();
    chk("abort_ready_end", 32'(cmd_ready), 1);
    chk("abort_rd_valid_end", 32'(rd_valid), 0);
    chk("abort_rd_data", 32'(rd_data), 32'(exp_rd));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
